// File: rtl/ped_signal_controller.sv
// Pedestrian crossing controller slaved to an upstream vehicle traffic light.
// A button press is served as a walk/clearance sequence inside one red phase.
// Losing red mid-sequence aborts the sequence. Illegal lamp combinations force
// a safe idle state while keeping any outstanding request.
module ped_signal_controller #(
  parameter int unsigned WALK_TIME  = 3,
  parameter int unsigned CLEAR_TIME = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ped_btn_i,
  input  logic       red_i,
  input  logic       yellow_i,
  input  logic       green_i,
  output logic       walk_o,
  output logic       dont_walk_o,
  output logic       flash_o,
  output logic       ped_wait_o,
  output logic [3:0] countdown_o,
  output logic       abort_o,
  output logic       fault_o
);

  localparam logic [3:0] WalkLoad  = 4'(WALK_TIME - 1);
  localparam logic [3:0] ClearLoad = 4'(CLEAR_TIME - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StWalk,
    StClear,
    StLockout
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       pending_q, pending_d;
  logic       flash_q, flash_d;
  logic       abort_q, abort_d;
  logic       btn_q, red_q;

  logic       btn_edge;
  logic       red_rise;
  logic       fault;
  logic [1:0] lamp_cnt;

  // Request/red edge detection and lamp legality check.
  always_comb begin
    btn_edge = ped_btn_i & ~btn_q;
    red_rise = red_i & ~red_q;
    lamp_cnt = {1'b0, red_i} + {1'b0, yellow_i} + {1'b0, green_i};
    fault    = (lamp_cnt != 2'd1);
  end

  // Next-state logic; a lamp fault overrides everything else.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    flash_d   = flash_q;
    abort_d   = 1'b0;

    if (fault) begin
      state_d   = StIdle;
      timer_d   = '0;
      flash_d   = 1'b0;
      // Fold a waiting request into pending so it is re-served afterwards.
      pending_d = pending_q | (state_q == StWait);
    end else begin
      unique case (state_q)
        StIdle: begin
          // pending can only be set here after a fault dropped us out of WAIT/LOCKOUT.
          if (pending_q || btn_edge) begin
            pending_d = 1'b0;
            if (red_rise) begin
              state_d = StWalk;
              timer_d = WalkLoad;
            end else begin
              state_d = StWait;
            end
          end
        end

        StWait: begin
          if (red_rise) begin
            state_d = StWalk;
            timer_d = WalkLoad;
          end
        end

        StWalk: begin
          if (!red_i) begin
            state_d = StIdle;
            timer_d = '0;
            abort_d = 1'b1;
          end else if (timer_q == 4'd0) begin
            state_d = StClear;
            timer_d = ClearLoad;
            flash_d = 1'b0;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end

        StClear: begin
          if (!red_i) begin
            state_d = StIdle;
            timer_d = '0;
            flash_d = 1'b0;
            abort_d = 1'b1;
          end else if (timer_q == 4'd0) begin
            state_d = StLockout;
            flash_d = 1'b0;
          end else begin
            timer_d = timer_q - 4'd1;
            flash_d = ~flash_q;
          end
        end

        StLockout: begin
          // One request may be queued here, to be served in the next red phase.
          if (!red_i) begin
            state_d   = (pending_q || btn_edge) ? StWait : StIdle;
            pending_d = 1'b0;
          end else if (btn_edge) begin
            pending_d = 1'b1;
          end
        end

        default: begin
          state_d   = StIdle;
          timer_d   = '0;
          pending_d = 1'b0;
          flash_d   = 1'b0;
        end
      endcase
    end
  end

  // State and sample registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      pending_q <= 1'b0;
      flash_q   <= 1'b0;
      abort_q   <= 1'b0;
      btn_q     <= 1'b0;
      red_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      flash_q   <= flash_d;
      abort_q   <= abort_d;
      btn_q     <= ped_btn_i;
      red_q     <= red_i;
    end
  end

  // Output decode from registered state; walk is also gated by a live fault.
  always_comb begin
    walk_o      = (state_q == StWalk) & ~fault;
    dont_walk_o = ~walk_o;
    flash_o     = (state_q == StClear) & flash_q;
    ped_wait_o  = (state_q == StWait) | pending_q;
    countdown_o = ((state_q == StWalk) || (state_q == StClear)) ? timer_q : 4'd0;
    abort_o     = abort_q;
    fault_o     = fault;
  end

endmodule

// File: tb/tb_ped_signal_controller.sv
// Randomized bench for ped_signal_controller. A generator plays a traffic
// light with random phase lengths, button toggles, lamp faults and reset
// pulses. A reference model tracks how far into a walk sequence we are.
// Expected outputs for each cycle are queued, and a negedge monitor
// compares them against the DUT.
module tb_ped_signal_controller;

  localparam int W = 3;
  localparam int C = 2;
  localparam int NumCycles = 4000;

  typedef struct packed {
    logic       walk;
    logic       dont_walk;
    logic       flash;
    logic       ped_wait;
    logic [3:0] countdown;
    logic       abort;
    logic       fault;
  } out_t;

  logic       clk;
  logic       rst_n;
  logic       ped_btn, red, yellow, green;
  logic       walk, dont_walk, flash, ped_wait, abort, fault;
  logic [3:0] countdown;

  int n_checks = 0;
  int n_errors = 0;
  out_t exp_q[$];

  // Model: m_age is the number of cycles into the walk sequence.
  // It is -1 when there is no sequence.
  // Ages W+C and above mean the sequence is spent and waiting for red to drop.
  int m_age;
  bit m_req, m_abort, m_prev_btn, m_prev_red;

  // Generator state.
  int phase, phase_left, flt_left, rst_left;
  logic [2:0] lamps;

  ped_signal_controller #(
    .WALK_TIME (W),
    .CLEAR_TIME(C)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ped_btn_i  (ped_btn),
    .red_i      (red),
    .yellow_i   (yellow),
    .green_i    (green),
    .walk_o     (walk),
    .dont_walk_o(dont_walk),
    .flash_o    (flash),
    .ped_wait_o (ped_wait),
    .countdown_o(countdown),
    .abort_o    (abort),
    .fault_o    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_age      = -1;
    m_req      = 1'b0;
    m_abort    = 1'b0;
    m_prev_btn = 1'b0;
    m_prev_red = 1'b0;
  endtask

  // Advance the model by one clock edge, using the inputs held during the cycle.
  task automatic model_step();
    bit edge_b, rise, flt;
    edge_b  = ped_btn & ~m_prev_btn;
    rise    = red & ~m_prev_red;
    flt     = (int'(red) + int'(yellow) + int'(green)) != 1;
    m_abort = 1'b0;
    if (flt) begin
      m_age = -1;  // sequence dropped; outstanding request survives
    end else if (m_age >= 0 && m_age < W + C) begin
      if (!red) begin
        m_age   = -1;
        m_abort = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_age >= 0) begin
      if (edge_b) m_req = 1'b1;
      if (!red) m_age = -1;
    end else if (m_req || edge_b) begin
      if (rise) begin
        m_age = 0;
        m_req = 1'b0;
      end else begin
        m_req = 1'b1;
      end
    end
    m_prev_btn = ped_btn;
    m_prev_red = red;
  endtask

  function automatic out_t expect_out();
    out_t o;
    bit in_walk, in_clear, flt;
    flt         = (int'(red) + int'(yellow) + int'(green)) != 1;
    in_walk     = (m_age >= 0) && (m_age < W);
    in_clear    = (m_age >= W) && (m_age < W + C);
    o.walk      = in_walk && !flt;
    o.dont_walk = !o.walk;
    o.flash     = in_clear && (((m_age - W) % 2) == 1);
    o.ped_wait  = m_req;
    o.countdown = in_walk ? 4'(W - 1 - m_age) : in_clear ? 4'(W + C - 1 - m_age) : 4'd0;
    o.abort     = m_abort;
    o.fault     = flt;
    return o;
  endfunction

  task automatic next_inputs();
    if (phase_left == 0) begin
      phase = (phase + 1) % 3;
      case (phase)
        0:       phase_left = $urandom_range(2, 6);
        1:       phase_left = $urandom_range(1, 2);
        default: phase_left = $urandom_range(3, 9);
      endcase
    end
    phase_left--;
    lamps = (phase == 0) ? 3'b001 : (phase == 1) ? 3'b010 : 3'b100;
    if (flt_left == 0 && $urandom_range(0, 59) == 0) flt_left = $urandom_range(1, 3);
    if (flt_left > 0) begin
      flt_left--;
      case ($urandom_range(0, 4))
        0:       lamps = 3'b000;
        1:       lamps = 3'b011;
        2:       lamps = 3'b101;
        3:       lamps = 3'b110;
        default: lamps = 3'b111;
      endcase
    end
    {red, yellow, green} = lamps;
    if ($urandom_range(0, 5) == 0) ped_btn = ~ped_btn;
    if (rst_left > 0) begin
      rst_left--;
      if (rst_left == 0) rst_n = 1'b1;
    end else if ($urandom_range(0, 399) == 0) begin
      rst_n    = 1'b0;
      rst_left = $urandom_range(1, 2);
      model_reset();
    end
  endtask

  // Stimulus: step the model at each edge, drive new inputs, queue the expectation.
  initial begin
    rst_n      = 1'b0;
    ped_btn    = 1'b0;
    red        = 1'b0;
    yellow     = 1'b0;
    green      = 1'b1;
    phase      = 2;
    phase_left = 0;
    flt_left   = 0;
    rst_left   = 2;
    model_reset();
    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      next_inputs();
      exp_q.push_back(expect_out());
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Monitor: compare one queued expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      chk("walk", {3'b0, walk}, {3'b0, e.walk});
      chk("dont_walk", {3'b0, dont_walk}, {3'b0, e.dont_walk});
      chk("flash", {3'b0, flash}, {3'b0, e.flash});
      chk("ped_wait", {3'b0, ped_wait}, {3'b0, e.ped_wait});
      chk("countdown", countdown, e.countdown);
      chk("abort", {3'b0, abort}, {3'b0, e.abort});
      chk("fault", {3'b0, fault}, {3'b0, e.fault});
    end
  end

endmodule
